// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge
//   Bridges a 16-bit word-oriented CPU port onto an 8-bit physical memory
//   port. Each CPU access is split into at most two byte accesses: the low
//   byte at the even address (LO), then the high byte at address|1 (HI).
//   Reads always fetch both bytes. Writes touch only the enabled lanes.
//
// Handshake:
//   The CPU holds mem_read/mem_write until mem_resp pulses for one cycle.
//   Each physical strobe is held, with address and data stable, until
//   pmem_resp is seen in the same cycle. The strobe then drops, or moves to
//   the next byte.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   mem_address         CPU word address (bit 0 ignored)
//   mem_read/mem_write  CPU request strobes (read wins if both)
//   mem_byte_enable     write lane mask, [0]=low byte, [1]=high byte
//   mem_wdata/rdata     CPU write/read data
//   mem_resp            one-cycle completion pulse
//   pmem_address        physical byte address
//   pmem_read/write     physical byte strobes
//   pmem_wdata/rdata    physical write/read byte
//   pmem_resp           physical access complete
module mem_byte_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic [15:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [7:0]  pmem_wdata,
    input  logic [7:0]  pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        is_read_q, is_read_d;
    logic [15:0] rdata_q, rdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            be_q      <= 2'b00;
            is_read_q <= 1'b0;
            rdata_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            is_read_q <= is_read_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        is_read_d    = is_read_q;
        rdata_d      = rdata_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 8'h00;

        case (state_q)
            ST_IDLE: begin
                // The request is captured in full here, so CPU inputs that
                // change during the access cannot disturb it.
                if (mem_read || mem_write) begin
                    addr_d    = {mem_address[15:1], 1'b0};
                    wdata_d   = mem_wdata;
                    be_d      = mem_byte_enable;
                    is_read_d = mem_read;
                    if (mem_read || mem_byte_enable[0]) begin
                        state_d = ST_LO;
                    end else if (mem_byte_enable[1]) begin
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LO: begin
                pmem_address = addr_q;
                pmem_read    = is_read_q;
                pmem_write   = !is_read_q;
                pmem_wdata   = wdata_q[7:0];
                if (pmem_resp) begin
                    if (is_read_q) begin
                        rdata_d[7:0] = pmem_rdata;
                    end
                    state_d = (is_read_q || be_q[1]) ? ST_HI : ST_DONE;
                end
            end
            ST_HI: begin
                pmem_address = addr_q | 16'h0001;
                pmem_read    = is_read_q;
                pmem_write   = !is_read_q;
                pmem_wdata   = wdata_q[15:8];
                if (pmem_resp) begin
                    if (is_read_q) begin
                        rdata_d[15:8] = pmem_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A request still pending here is held off until IDLE.
                mem_resp = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_byte_bridge.sv
module tb_mem_byte_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [7:0]  pmem_wdata;
    logic [7:0]  pmem_rdata;
    logic        pmem_resp;

    mem_byte_bridge dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Counters and scoreboard state
    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  phys_mem [0:65535];
    logic [7:0]  ref_mem  [0:65535];
    logic [24:0] exp_acc_q [$];   // {is_write, byte address, byte data}
    logic [16:0] exp_resp_q [$];  // {is_read, expected read word}
    logic [15:0] last_rd = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Physical memory model: responds after cur_lat wait cycles per byte.
    // Outside a strobe it drives random noise on pmem_resp.
    int   cur_lat = 0;
    int   wait_cnt = 0;
    logic noise = 1'b0;
    logic strobe;

    assign strobe     = pmem_read | pmem_write;
    assign pmem_resp  = strobe ? (wait_cnt >= cur_lat) : noise;
    assign pmem_rdata = pmem_read ? phys_mem[pmem_address] : 8'h5A;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 0;
        end else if (strobe && !pmem_resp) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        noise = 1'($urandom_range(0, 1));
    end

    // Monitor: samples on the falling edge, pops expectations as the DUT
    // completes physical and CPU transactions
    logic        held_prev = 1'b0;
    logic [15:0] held_addr = 16'h0000;
    logic [7:0]  held_wdata = 8'h00;
    logic [24:0] obs_acc;
    logic [16:0] exp_resp;

    always @(negedge clk) begin
        if (reset) begin
            held_prev = 1'b0;
        end else begin
            chk("strobe_exclusive", {31'd0, pmem_read && pmem_write}, 32'd0);
            if (!strobe) begin
                chk("wdata_idle_zero", {24'd0, pmem_wdata}, 32'd0);
                held_prev = 1'b0;
            end else begin
                if (held_prev) begin
                    chk("addr_hold", {16'd0, pmem_address}, {16'd0, held_addr});
                    chk("wdata_hold", {24'd0, pmem_wdata}, {24'd0, held_wdata});
                end
                held_addr  = pmem_address;
                held_wdata = pmem_wdata;
                held_prev  = !pmem_resp;
                if (pmem_resp) begin
                    obs_acc = {pmem_write, pmem_address, pmem_write ? pmem_wdata : pmem_rdata};
                    if (exp_acc_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pmem_unexpected: got access 0x%0h, expected none", obs_acc);
                    end else begin
                        chk("pmem_access", {7'd0, obs_acc}, {7'd0, exp_acc_q.pop_front()});
                    end
                    if (pmem_write) begin
                        phys_mem[pmem_address] = pmem_wdata;
                    end
                end
            end
            if (mem_resp) begin
                if (exp_resp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mem_resp_unexpected: got mem_resp=1, expected no response");
                end else begin
                    exp_resp = exp_resp_q.pop_front();
                    if (exp_resp[16]) begin
                        chk("mem_rdata", {16'd0, mem_rdata}, {16'd0, exp_resp[15:0]});
                    end
                end
            end
        end
    end

    // Driver: one CPU transaction, expectations derived from the reference
    // memory; called #1 after a rising edge with the DUT idle
    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [1:0] be, input logic [15:0] wd, input int lat);
        logic [15:0] lo_a;
        logic [15:0] hi_a;
        int          nacc;
        int          n;
        logic        done;
        lo_a = {addr[15:1], 1'b0};
        hi_a = lo_a | 16'h0001;
        nacc = 0;
        if (rd) begin
            exp_acc_q.push_back({1'b0, lo_a, ref_mem[lo_a]});
            exp_acc_q.push_back({1'b0, hi_a, ref_mem[hi_a]});
            exp_resp_q.push_back({1'b1, ref_mem[hi_a], ref_mem[lo_a]});
            last_rd = {ref_mem[hi_a], ref_mem[lo_a]};
            nacc = 2;
        end else if (wr) begin
            if (be[0]) begin
                exp_acc_q.push_back({1'b1, lo_a, wd[7:0]});
                ref_mem[lo_a] = wd[7:0];
                nacc++;
            end
            if (be[1]) begin
                exp_acc_q.push_back({1'b1, hi_a, wd[15:8]});
                ref_mem[hi_a] = wd[15:8];
                nacc++;
            end
            exp_resp_q.push_back({1'b0, 16'h0000});
        end
        cur_lat         = lat;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            // Scramble the non-strobe inputs once the request is accepted.
            mem_address     = 16'($urandom);
            mem_wdata       = 16'($urandom);
            mem_byte_enable = 2'($urandom_range(0, 3));
            if (mem_resp) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: no mem_resp after %0d cycles, expected one", n);
        end else begin
            chk("latency", n, 1 + nacc * (1 + lat));
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_single_pulse", {31'd0, mem_resp}, 32'd0);
        chk("rdata_hold", {16'd0, mem_rdata}, {16'd0, last_rd});
    endtask

    // Main stimulus
    initial begin
        logic [7:0] b;
        int         n;
        int         kind;
        reset           = 1'b1;
        mem_address     = 16'h0000;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_wdata       = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            phys_mem[i] = b;
            ref_mem[i]  = b;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {29'd0, mem_resp, pmem_read, pmem_write}, 32'd0);
        chk("reset_addr", {16'd0, pmem_address}, 32'd0);
        chk("reset_wdata", {24'd0, pmem_wdata}, 32'd0);
        chk("reset_rdata", {16'd0, mem_rdata}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait read of an odd address fetches the containing word
        phys_mem[16'h1234] = 8'hCD; ref_mem[16'h1234] = 8'hCD;
        phys_mem[16'h1235] = 8'hAB; ref_mem[16'h1235] = 8'hAB;
        do_txn(1'b1, 1'b0, 16'h1235, 2'b00, 16'h0000, 0);
        chk("read_word_0x1235", {16'd0, mem_rdata}, 32'h0000ABCD);

        // Two-lane write, then read back
        do_txn(1'b0, 1'b1, 16'h2000, 2'b11, 16'hBEEF, 0);
        do_txn(1'b1, 1'b0, 16'h2000, 2'b00, 16'h0000, 0);

        // High-only, low-only and empty-mask writes
        do_txn(1'b0, 1'b1, 16'h3000, 2'b10, 16'h5566, 0);
        do_txn(1'b0, 1'b1, 16'h3002, 2'b01, 16'h7788, 0);
        do_txn(1'b0, 1'b1, 16'h3000, 2'b00, 16'h9999, 0);
        do_txn(1'b1, 1'b0, 16'h3000, 2'b11, 16'h0000, 0);

        // Four wait cycles per byte
        do_txn(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, 4);

        // Read and write together: the read wins
        do_txn(1'b1, 1'b1, 16'h2000, 2'b11, 16'h1111, 0);

        // Reset during the HI byte of a read
        cur_lat = 2;
        exp_acc_q.push_back({1'b0, 16'h4400, ref_mem[16'h4400]});
        exp_acc_q.push_back({1'b0, 16'h4401, ref_mem[16'h4401]});
        exp_resp_q.push_back({1'b1, ref_mem[16'h4401], ref_mem[16'h4400]});
        mem_address = 16'h4401;
        mem_read    = 1'b1;
        n = 0;
        while (!(pmem_read && pmem_address[0]) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_hi_read", {31'd0, pmem_read && pmem_address[0]}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_ctl", {29'd0, mem_resp, pmem_read, pmem_write}, 32'd0);
        chk("abort_addr", {16'd0, pmem_address}, 32'd0);
        chk("abort_wdata", {24'd0, pmem_wdata}, 32'd0);
        chk("abort_rdata", {16'd0, mem_rdata}, 32'd0);
        chk("abort_pending_acc", exp_acc_q.size(), 32'd1);
        chk("abort_pending_resp", exp_resp_q.size(), 32'd1);
        exp_acc_q.delete();
        exp_resp_q.delete();
        mem_read = 1'b0;
        last_rd  = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_txn(1'b1, 1'b0, 16'h4400, 2'b00, 16'h0000, 0);

        // Randomized traffic over a small window so reads see earlier writes
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            do_txn(kind <= 3 || kind == 9, kind >= 4,
                   16'h8000 | 16'($urandom_range(0, 63)),
                   2'($urandom_range(0, 3)), 16'($urandom),
                   $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("acc_queue_drained", exp_acc_q.size(), 32'd0);
        chk("resp_queue_drained", exp_resp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_byte_bridge.md
MEM_BYTE_BRIDGE -- requirements
Module: mem_byte_bridge

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 mem_address  in  16  CPU word address; bit 0 ignored.
REQ-005 mem_read  in  1  CPU read request, held until mem_resp.
REQ-006 mem_write  in  1  CPU write request, held until mem_resp.
REQ-007 mem_byte_enable  in  2  write lane mask; [0]=low byte, [1]=high byte.
REQ-008 mem_wdata  in  16  CPU write data.
REQ-009 mem_rdata  out  16  CPU read data.
REQ-010 mem_resp  out  1  one-cycle completion pulse to CPU.
REQ-011 pmem_address  out  16  physical byte address.
REQ-012 pmem_read  out  1  physical byte read strobe.
REQ-013 pmem_write  out  1  physical byte write strobe.
REQ-014 pmem_wdata  out  8  physical write byte.
REQ-015 pmem_rdata  in  8  physical read byte, valid when pmem_resp=1.
REQ-016 pmem_resp  in  1  physical access complete; may be combinational from the strobes.

Function
REQ-017 FSM states: IDLE, LO, HI, DONE; converts each 16-bit CPU access into up to two 8-bit physical accesses.
REQ-018 IDLE: if mem_read=1 or mem_write=1, latch address (bit 0 forced to 0), wdata, byte_enable and op; read priority when both are asserted (write ignored).
REQ-019 IDLE -> LO for any read, or for a write with byte_enable[0]=1; IDLE -> HI for a write with byte_enable=10; IDLE -> DONE for a write with byte_enable=00.
REQ-020 LO: pmem_address = latched_addr, strobe held high until pmem_resp; on pmem_resp, read captures pmem_rdata into rdata[7:0].
REQ-021 LO exit on pmem_resp: -> HI for a read or a write with byte_enable[1]=1; otherwise -> DONE.
REQ-022 HI: pmem_address = latched_addr|1, strobe held until pmem_resp; read captures rdata[15:8]; on pmem_resp -> DONE.
REQ-023 Reads always fetch both bytes, regardless of mem_byte_enable.
REQ-024 pmem_wdata = wdata[7:0] in LO, wdata[15:8] in HI, 0 otherwise.
REQ-025 pmem_read/pmem_write asserted only in LO/HI, never both; address and wdata stable while a strobe is high.
REQ-026 DONE: mem_resp=1 for exactly one cycle, then -> IDLE unconditionally; a new request is not accepted in DONE.
REQ-027 mem_rdata is driven from the capture register; stable from DONE until the next read's LO capture.
REQ-028 CPU input changes after acceptance have no effect until the next IDLE.
REQ-029 pmem_resp outside LO/HI is ignored.
REQ-030 Latency with zero-wait pmem: read or two-lane write = request cycle + LO + HI, mem_resp in cycle 3; single-lane write gives mem_resp in cycle 2; byte_enable=00 write gives mem_resp in cycle 1.

Reset
REQ-031 reset=1 forces IDLE immediately and asynchronously: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_rdata=0.
REQ-032 Reset during LO/HI aborts the access with no mem_resp; a partial write is not rolled back.

Verification
REQ-033 Zero-wait read, addr 0x1235, pmem bytes [0x1234]=0xCD, [0x1235]=0xAB -> pmem_address 0x1234 then 0x1235, mem_resp in cycle 3, mem_rdata=0xABCD.
REQ-034 Write 0xBEEF, be=11, addr 0x2000 -> pmem writes 0xEF@0x2000 then 0xBE@0x2001, one mem_resp.
REQ-035 Write be=10, addr 0x3000, data 0x5566 -> single pmem write 0x55@0x3001, no access to 0x3000; be=00 -> no pmem strobe, mem_resp in cycle 1.
REQ-036 Read with pmem_resp delayed 4 cycles per byte -> strobe and address held, mem_resp in cycle 11, exactly one pulse.
REQ-037 mem_read and mem_write both high -> read performed, no pmem_write observed.
REQ-038 Reset asserted in HI of a read -> outputs zero immediately, no mem_resp; next read completes normally.
